// File: rtl/mul_div_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package mul_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bit positions inside Mul_Div_unsigned
  localparam int unsigned RS1_UNS = 1;
  localparam int unsigned RS2_UNS = 0;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/mul_div_iter_step.sv
// One iteration of shift-add multiply and restoring divide.
module mul_div_iter_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] prod_i,
  input  logic [XLEN-1:0]   mcand_i,
  input  logic [XLEN:0]     rem_i,
  input  logic [XLEN-1:0]   quot_i,
  input  logic [XLEN-1:0]   divisor_i,
  output logic [2*XLEN-1:0] prod_o,
  output logic [XLEN:0]     rem_o,
  output logic [XLEN-1:0]   quot_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Multiplier sits in the low half and is consumed LSB first; the carry
  // of the add is kept by shifting the XLEN+1 bit sum into the top.
  always_comb begin
    sum     = {1'b0, prod_i[2*XLEN-1:XLEN]} + (prod_i[0] ? {1'b0, mcand_i} : '0);
    prod_o  = {sum, prod_i[XLEN-1:1]};
    shifted = {rem_i[XLEN-1:0], quot_i[XLEN-1]};
    diff    = shifted - {1'b0, divisor_i};
    if (diff[XLEN]) begin
      rem_o  = shifted;
      quot_o = {quot_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o  = diff;
      quot_o = {quot_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide execute unit with start/busy/done handshake.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic            is_div,
  input  logic            is_high,
  input  logic [1:0]      Mul_Div_unsigned,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              is_div_q, is_high_q, neg_q, neg_r_q, div0_q, ovf_q;
  logic [XLEN-1:0]   dvd_q, b_q, quot_q;
  logic [XLEN:0]     rem_q;
  logic [2*XLEN-1:0] prod_q;

  logic              sa, sb, div0, ovf;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [2*XLEN-1:0] prod_d, prod_s;
  logic [XLEN:0]     rem_d;
  logic [XLEN-1:0]   quot_d, quot_s, rem_s, result_d;

  mul_div_iter_step #(.XLEN(XLEN)) u_step (
    .prod_i    (prod_q),
    .mcand_i   (b_q),
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (b_q),
    .prod_o    (prod_d),
    .rem_o     (rem_d),
    .quot_o    (quot_d)
  );

  always_comb begin
    sa    = rs1[XLEN-1] & ~Mul_Div_unsigned[RS1_UNS];
    sb    = rs2[XLEN-1] & ~Mul_Div_unsigned[RS2_UNS];
    a_abs = sa ? -rs1 : rs1;
    b_abs = sb ? -rs2 : rs2;
    div0  = (rs2 == '0);
    ovf   = ~Mul_Div_unsigned[RS1_UNS] & ~Mul_Div_unsigned[RS2_UNS]
            & (rs1 == INT_MIN) & (rs2 == '1);
  end

  always_comb begin
    prod_s = neg_q   ? -prod_q : prod_q;
    quot_s = neg_q   ? -quot_q : quot_q;
    rem_s  = neg_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    if (!is_div_q)
      result_d = is_high_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    else if (div0_q)
      result_d = is_high_q ? dvd_q : DIV0_QUOT;
    else if (ovf_q)
      result_d = is_high_q ? '0 : INT_MIN;
    else
      result_d = is_high_q ? rem_s : quot_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      is_high_q <= 1'b0;
      neg_q     <= 1'b0;
      neg_r_q   <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      dvd_q     <= '0;
      b_q       <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      prod_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else if (kill) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            is_div_q  <= is_div;
            is_high_q <= is_high;
            neg_q     <= sa ^ sb;
            neg_r_q   <= sa;
            div0_q    <= is_div & div0;
            ovf_q     <= is_div & ovf;
            dvd_q     <= rs1;
            b_q       <= b_abs;
            quot_q    <= a_abs;
            rem_q     <= '0;
            prod_q    <= {{XLEN{1'b0}}, a_abs};
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= (is_div & (div0 | ovf)) ? FIX : CALC;
          end
        end
        CALC: begin
          prod_q <= prod_d;
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == LAST)
            state_q <= FIX;
        end
        FIX: begin
          result  <= result_d;
          done    <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic        is_div = 1'b0;
  logic        is_high = 1'b0;
  logic [1:0]  uns = 2'b00;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .kill             (kill),
    .is_div           (is_div),
    .is_high          (is_high),
    .Mul_Div_unsigned (uns),
    .rs1              (rs1),
    .rs2              (rs2),
    .busy             (busy),
    .done             (done),
    .result           (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start sampled at the first edge (cycle 0); operands scrambled afterwards.
  task automatic issue(input logic d, input logic h, input logic [1:0] u,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; is_div = d; is_high = h; uns = u; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0; rs1 = 32'h1234_5678; rs2 = 32'h0000_0000;
    is_high = ~h; uns = ~u;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  task automatic run(input string tag, input logic d, input logic h, input logic [1:0] u,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input int exp_lat);
    int lat;
    issue(d, h, u, a, b);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, result, exp_res);
    @(posedge clk); #1;
    chk({tag, "_idle"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int lat;
    int ndone;

    #12;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_res", result, 32'd0);
    rst_n = 1'b1;

    run("mul",    1'b0, 1'b0, 2'b00, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run("mulh",   1'b0, 1'b1, 2'b00, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 34);
    run("mulhu",  1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulhsu", 1'b0, 1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run("div0",   1'b1, 1'b0, 2'b00, 32'd5,         32'd0,         32'hFFFF_FFFF, 2);
    run("rem0",   1'b1, 1'b1, 2'b00, 32'd5,         32'd0,         32'd5,         2);
    run("divovf", 1'b1, 1'b0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run("removf", 1'b1, 1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);
    run("div",    1'b1, 1'b0, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run("rem",    1'b1, 1'b1, 2'b00, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run("divu",   1'b1, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 34);

    // kill at CALC counter 10 (11 edges after the start edge)
    issue(1'b0, 1'b0, 2'b00, 32'd7, 32'hFFFF_FFFD);
    repeat (10) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_done", {31'b0, done}, 32'd0);
    chk("kill_res", result, 32'h7FFF_FFFF);
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    chk("kill_nodone", ndone, 0);
    run("postkill", 1'b0, 1'b0, 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);

    // asynchronous reset in the middle of CALC
    issue(1'b0, 1'b0, 2'b11, 32'd3, 32'd5);
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_res", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // start while busy is ignored
    issue(1'b1, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'd2);
    repeat (5) begin @(posedge clk); #1; end
    start = 1'b1; is_div = 1'b0; is_high = 1'b0; uns = 2'b11; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    chk("busystart_lat", lat, 34 - 6);
    chk("busystart_res", result, 32'h7FFF_FFFF);
    ndone = 0;
    repeat (45) begin @(posedge clk); #1; if (done) ndone++; end
    chk("busystart_onedone", ndone, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
Iterative RV32M execute-stage unit. It consumes the multiply/divide controls the decode stage produces for funct7[0]=1 ops (Mul_Div_unsigned, is_high, funct3[2]) and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles. A start/busy/done handshake drives it, and the pipeline hazard logic stalls on it.

Parameters:
XLEN, 32, operand/result width; iteration count = XLEN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
kill  in  1  pipeline flush; aborts any operation in progress
is_div  in  1  1 = divide/remainder (funct3[2]=1), 0 = multiply
is_high  in  1  mul: 1 = upper XLEN bits of product; div: 1 = remainder, 0 = quotient
Mul_Div_unsigned  in  2  [1]=1: rs1 unsigned; [0]=1: rs2 unsigned
rs1  in  XLEN  operand A / dividend
rs2  in  XLEN  operand B / divisor
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse; result valid
result  out  XLEN  registered result; held until next done

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, counter=0, all datapath registers 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 & kill=0: latch operation fields; latch |rs1| and |rs2| (abs only when the operand is signed and negative); latch neg_q/neg_r flags.
  - Normal case: go to CALC with counter=0.
  - Special div cases go straight to FIX: divisor==0, or signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, both signed).
- CALC, one bit per cycle, exactly XLEN cycles (counter 0..XLEN-1):
  - mul: shift-add into a 2*XLEN product register.
  - div: restoring divide into an XLEN+1 remainder and an XLEN quotient.
  - Leave for FIX when counter==XLEN-1.
- FIX: apply sign correction and write result; next state DONE.
  - mul: negate the 2*XLEN product if neg = sA^sB, where sA = rs1[XLEN-1] & ~U[1] and sB = rs2[XLEN-1] & ~U[0]. result = is_high ? prod[2X-1:X] : prod[X-1:0].
  - div: quotient negated if dividend/divisor signs differ; remainder takes the dividend's sign.
  - Divide by zero: quotient = all ones; remainder = rs1 unchanged.
  - Signed overflow: quotient = 0x80000000; remainder = 0.
- DONE: done=1 for exactly this cycle; start is ignored; next state IDLE.
- Latency: start in cycle 0 gives done in cycle XLEN+2 (34) on the normal path and in cycle 2 on the special paths.
- busy rises the cycle after start is accepted and stays high through DONE.
- kill has priority over everything in any state: next state IDLE, no done, result unchanged. kill together with start in IDLE: the start is dropped.
- start while busy: ignored, no queuing. The pipeline must hold the instruction until done.
- The unit never captures rs1/rs2 after the start cycle, so operand changes later have no effect.
- Arithmetic is modulo 2^XLEN or 2^(2*XLEN); there are no exceptions.

Decomposition:
- Shared package mul_div_pkg:
  - state encoding localparams for IDLE/CALC/FIX/DONE;
  - bit positions of Mul_Div_unsigned (RS1_UNS=1, RS2_UNS=0);
  - the constants DIV0_QUOT (all ones) and INT_MIN (0x80000000).
- One natural sub-module, mul_div_iter_step: a combinational single-iteration shift-add / restore-subtract datapath. The FSM, counter and sign logic stay in mul_div_unit.

Test Plan:
- MUL: rs1=7, rs2=-3 (0xFFFFFFFD), U=00, is_high=0 → done at cycle 34, result=0xFFFFFFEB. MULH on the same operands → 0xFFFFFFFF.
- MULHU: rs1=rs2=0xFFFFFFFF, U=11, is_high=1 → 0xFFFFFFFE. MULHSU: rs1=-1, rs2=0xFFFFFFFF, U=01 → 0xFFFFFFFF.
- DIV/REM: rs1=-7, rs2=2 signed → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU: rs1=0xFFFFFFFF, rs2=2 → 0x7FFFFFFF.
- Special paths, each with done at cycle 2:
  - DIV rs2=0, rs1=5 → 0xFFFFFFFF;
  - REM rs2=0, rs1=5 → 5;
  - DIV 0x80000000 / -1 → 0x80000000;
  - REM 0x80000000 / -1 → 0.
- kill asserted at CALC cycle 10 → busy=0 next cycle, no done, result keeps its previous value. A new start then completes normally.
- rst_n pulsed low mid-CALC → busy/done/result go to 0 immediately (async). A start pulse during busy is ignored and yields only one done.
